// File: rtl/i2c_symbol_gen.sv
// One I2C bus symbol (START, STOP, WRITE bit, READ bit) per request, built from
// quarter-period phases, with clock-stretch timeout and arbitration-loss abort.
module i2c_symbol_gen #(
  parameter int CLK_FREQ        = 25_000_000,
  parameter int I2C_FREQ        = 100_000,
  parameter int SYNC_STAGES     = 2,
  parameter int STRETCH_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic [1:0] i_cmd,
  input  logic       i_wr_bit,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_rd_bit,
  output logic       o_arb_lost,
  output logic       o_timeout,
  output logic       o_bus_busy,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda_drive,
  output logic       o_scl_drive
);

  localparam int QUARTER = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int SW      = (STRETCH_TIMEOUT > 1) ? $clog2(STRETCH_TIMEOUT) : 1;

  if (QUARTER < 2) begin : g_bad_quarter
    $error("i2c_symbol_gen: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("i2c_symbol_gen: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_RISE, ST_HIGH, ST_HOLD, ST_FALL
  } state_t;

  typedef enum logic [1:0] {
    CMD_START = 2'd0, CMD_STOP = 2'd1, CMD_WRITE = 2'd2, CMD_READ = 2'd3
  } cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          stretch_q, stretch_d;
  logic                   wr_q, wr_d;
  logic                   sda_q, sda_d;
  logic                   scl_q, scl_d;
  logic                   done_q, done_d;
  logic                   rd_q, rd_d;
  logic                   arb_q, arb_d;
  logic                   to_q, to_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
  logic                   sda_s, scl_next;
  logic                   arb_hit, to_hit;

  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  // HIGH is entered on the same edge that the last SCL stage captures a 1,
  // so RISE lasts exactly SYNC_STAGES cycles when nobody stretches.
  assign scl_next = scl_sync_q[SYNC_STAGES-2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_START;
      cnt_q      <= '0;
      stretch_q  <= '0;
      wr_q       <= 1'b0;
      sda_q      <= 1'b1;
      scl_q      <= 1'b1;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      arb_q      <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_sync_q <= '1;
      scl_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      stretch_q  <= stretch_d;
      wr_q       <= wr_d;
      sda_q      <= sda_d;
      scl_q      <= scl_d;
      done_q     <= done_d;
      rd_q       <= rd_d;
      arb_q      <= arb_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    stretch_d = stretch_q;
    wr_d      = wr_q;
    sda_d     = sda_q;
    scl_d     = scl_q;
    done_d    = 1'b0;
    rd_d      = rd_q;
    arb_d     = arb_q;
    to_d      = to_q;
    busy_d    = busy_q;
    arb_hit   = 1'b0;
    to_hit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(QUARTER - 1);
          cmd_d   = cmd_t'(i_cmd);
          wr_d    = i_wr_bit;
          arb_d   = 1'b0;
          to_d    = 1'b0;
          unique case (cmd_t'(i_cmd))
            CMD_START: sda_d = 1'b1;
            CMD_STOP:  sda_d = 1'b0;
            CMD_WRITE: sda_d = i_wr_bit;
            default:   sda_d = 1'b1;
          endcase
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d   = ST_RISE;
          scl_d     = 1'b1;
          stretch_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RISE: begin
        if (scl_next) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(QUARTER - 1);
        end else if (stretch_q == SW'(STRETCH_TIMEOUT - 1)) begin
          to_hit = 1'b1;
        end else begin
          stretch_d = stretch_q + 1'b1;
        end
      end

      // End of the SCL-high window: sample, check arbitration, enter HOLD.
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(QUARTER - 1);
          unique case (cmd_q)
            CMD_START: begin
              if (!sda_s) arb_hit = 1'b1;
              else        sda_d   = 1'b0;
            end
            CMD_WRITE: begin
              if (wr_q && !sda_s) arb_hit = 1'b1;
            end
            CMD_READ:  rd_d  = sda_s;
            default:   sda_d = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_FALL;
          cnt_d   = CW'(QUARTER - 1);
          if (cmd_q == CMD_STOP) begin
            if (!sda_s) arb_hit = 1'b1;
          end else begin
            scl_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FALL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (cmd_q == CMD_START) busy_d = 1'b1;
          if (cmd_q == CMD_STOP)  busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Losing the bus either way releases both lines and ends the symbol now.
    if (arb_hit || to_hit) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      scl_d   = 1'b1;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      if (arb_hit) arb_d = 1'b1;
      if (to_hit)  to_d  = 1'b1;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_done      = done_q;
  assign o_rd_bit    = rd_q;
  assign o_arb_lost  = arb_q;
  assign o_timeout   = to_q;
  assign o_bus_busy  = busy_q;
  assign o_sda_drive = sda_q;
  assign o_scl_drive = scl_q;

endmodule

// File: tb/tb_i2c_symbol_gen.sv
// Directed bench for i2c_symbol_gen: Q=10, two sync stages, open-drain bus with
// pull-ups, a slave that can stretch SCL / drive SDA, and a rival master on SDA.
module tb_i2c_symbol_gen;

  localparam int Q            = 10;
  localparam int T_SYM        = 4 * Q + 2;
  localparam int T_FREE_START = 4 * Q + 1;
  localparam int T_ARB        = 2 * Q + 2;
  localparam int T_STRETCH    = T_SYM + 98;
  localparam int T_TIMEOUT    = Q + 4096;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_req;
  logic [1:0] i_cmd;
  logic       i_wr_bit;
  logic       o_ready, o_done, o_rd_bit, o_arb_lost, o_timeout, o_bus_busy;
  logic       o_sda_drive, o_scl_drive;
  logic       slaveSda, slaveScl, otherSda;
  logic       sdaBus, sclBus;
  logic [7:0] outVec;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int glitchCount = 0;
  logic monitorOn = 1'b0;
  logic prevSda = 1'b1;
  logic prevScl = 1'b1;

  assign sdaBus = o_sda_drive & slaveSda & otherSda;
  assign sclBus = o_scl_drive & slaveScl;
  assign outVec = {o_sda_drive, o_scl_drive, o_ready, o_done,
                   o_rd_bit, o_arb_lost, o_timeout, o_bus_busy};

  i2c_symbol_gen #(
    .CLK_FREQ(4_000_000),
    .I2C_FREQ(100_000),
    .SYNC_STAGES(2),
    .STRETCH_TIMEOUT(4096)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req(i_req),
    .i_cmd(i_cmd),
    .i_wr_bit(i_wr_bit),
    .o_ready(o_ready),
    .o_done(o_done),
    .o_rd_bit(o_rd_bit),
    .o_arb_lost(o_arb_lost),
    .o_timeout(o_timeout),
    .o_bus_busy(o_bus_busy),
    .i_sda(sdaBus),
    .i_scl(sclBus),
    .o_sda_drive(o_sda_drive),
    .o_scl_drive(o_scl_drive)
  );

  // Free-running clock; cyc equals the number of rising edges seen so far.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Data must not move while SCL is high during WRITE bits.
  always @(negedge i_clk) begin
    if (monitorOn && prevScl && sclBus && (sdaBus !== prevSda))
      glitchCount <= glitchCount + 1;
    prevScl <= sclBus;
    prevSda <= sdaBus;
  end

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; issues the request and returns the accept edge.
  task automatic applyStimulus(input logic [1:0] cmd, input logic wr, output int acc);
    int guard;
    guard = 0;
    while (!o_ready && guard < 10000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) checkOutput("ready_wait", 32'(o_ready), 32'd1);
    i_req    = 1'b1;
    i_cmd    = cmd;
    i_wr_bit = wr;
    @(negedge i_clk);
    acc   = cyc;
    i_req = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) checkOutput("done_wait", 32'(o_done), 32'd1);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge i_clk);
  endtask

  initial begin
    int acc, dn, prevDone;
    logic [3:0] bits;
    logic doneSeen;

    i_rst_n  = 1'b1;
    i_req    = 1'b0;
    i_cmd    = 2'd0;
    i_wr_bit = 1'b0;
    slaveSda = 1'b1;
    slaveScl = 1'b1;
    otherSda = 1'b1;

    // Reset values appear before any clock edge.
    #1 i_rst_n = 1'b0;
    #2 checkOutput("reset_outputs", 32'(outVec), 32'(8'b1110_0000));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // START on a free bus: SCL already high, so RISE is a single cycle.
    applyStimulus(CMD_START, 1'b0, acc);
    checkOutput("start_setup_drives", 32'({o_sda_drive, o_scl_drive}), 32'(2'b11));
    waitUntil(acc + 20);
    checkOutput("start_high_sda", 32'(o_sda_drive), 32'd1);
    waitUntil(acc + 21);
    checkOutput("start_hold_drives", 32'({o_sda_drive, o_scl_drive}), 32'(2'b01));
    waitUntil(acc + 31);
    checkOutput("start_fall_scl", 32'(o_scl_drive), 32'd0);
    waitDone(200, dn);
    checkOutput("start_latency", 32'(dn - acc), 32'(T_FREE_START));
    checkOutput("start_busy", 32'(o_bus_busy), 32'd1);
    checkOutput("start_done_ready", 32'(o_ready), 32'd1);

    // WRITE 1,0,1,1 back-to-back, each bit checked in its SCL-high window.
    bits = 4'b1011;
    monitorOn = 1'b1;
    prevDone = dn;
    for (int b = 3; b >= 0; b--) begin
      applyStimulus(CMD_WRITE, bits[b], acc);
      checkOutput("write_back_to_back", 32'(acc - prevDone), 32'd1);
      waitUntil(acc + 15);
      checkOutput("write_high_sda", 32'({sclBus, o_sda_drive}), 32'({1'b1, bits[b]}));
      waitDone(200, dn);
      checkOutput("write_latency", 32'(dn - acc), 32'(T_SYM));
      prevDone = dn;
    end
    monitorOn = 1'b0;
    checkOutput("write_sda_stable", 32'(glitchCount), 32'd0);

    // STOP closes the transaction with both lines released.
    applyStimulus(CMD_STOP, 1'b0, acc);
    waitUntil(acc + 5);
    checkOutput("stop_setup_sda", 32'(o_sda_drive), 32'd0);
    waitDone(200, dn);
    checkOutput("stop_latency", 32'(dn - acc), 32'(T_SYM));
    checkOutput("stop_end_state", 32'({o_sda_drive, o_scl_drive, sdaBus, sclBus, o_bus_busy}),
                32'(5'b11110));

    // READs with the slave presenting 0, 1, 0.
    applyStimulus(CMD_START, 1'b0, acc);
    waitDone(200, dn);
    slaveSda = 1'b0;
    applyStimulus(CMD_READ, 1'b0, acc);
    waitDone(200, dn);
    checkOutput("read0_bit", 32'(o_rd_bit), 32'd0);
    checkOutput("read0_latency", 32'(dn - acc), 32'(T_SYM));
    slaveSda = 1'b1;
    applyStimulus(CMD_READ, 1'b0, acc);
    waitDone(200, dn);
    checkOutput("read1_bit", 32'(o_rd_bit), 32'd1);
    slaveSda = 1'b0;
    applyStimulus(CMD_READ, 1'b0, acc);
    waitDone(200, dn);
    checkOutput("read0_again_bit", 32'(o_rd_bit), 32'd0);
    slaveSda = 1'b1;

    // Slave stretches SCL from SETUP cycle 8 for 100 cycles.
    applyStimulus(CMD_WRITE, 1'b1, acc);
    waitUntil(acc + 8);
    slaveScl = 1'b0;
    waitUntil(acc + 108);
    slaveScl = 1'b1;
    waitDone(400, dn);
    checkOutput("stretch_latency", 32'(dn - acc), 32'(T_STRETCH));
    checkOutput("stretch_no_timeout", 32'(o_timeout), 32'd0);

    // Slave holds SCL for 5000 cycles: abort after 4096 RISE cycles.
    applyStimulus(CMD_WRITE, 1'b0, acc);
    waitUntil(acc + 8);
    slaveScl = 1'b0;
    waitDone(6000, dn);
    checkOutput("timeout_latency", 32'(dn - acc), 32'(T_TIMEOUT));
    checkOutput("timeout_status", 32'({o_timeout, o_arb_lost, o_bus_busy}), 32'(3'b100));
    checkOutput("timeout_drives", 32'({o_sda_drive, o_scl_drive}), 32'(2'b11));
    waitUntil(acc + 5008);
    slaveScl = 1'b1;
    @(negedge i_clk);

    applyStimulus(CMD_START, 1'b0, acc);
    checkOutput("timeout_cleared", 32'(o_timeout), 32'd0);
    waitDone(200, dn);

    // Rival master pulls SDA low during our WRITE 1.
    applyStimulus(CMD_WRITE, 1'b1, acc);
    otherSda = 1'b0;
    waitDone(200, dn);
    checkOutput("arb_latency", 32'(dn - acc), 32'(T_ARB));
    checkOutput("arb_status", 32'({o_arb_lost, o_timeout, o_bus_busy}), 32'(3'b100));
    checkOutput("arb_drives", 32'({o_sda_drive, o_scl_drive}), 32'(2'b11));
    otherSda = 1'b1;
    @(negedge i_clk);
    applyStimulus(CMD_START, 1'b0, acc);
    checkOutput("arb_cleared", 32'(o_arb_lost), 32'd0);
    waitDone(200, dn);
    checkOutput("restart_busy", 32'(o_bus_busy), 32'd1);

    // Asynchronous reset in the middle of a WRITE 0 HIGH phase.
    applyStimulus(CMD_WRITE, 1'b0, acc);
    waitUntil(acc + 15);
    checkOutput("pre_reset_drives", 32'({o_sda_drive, o_scl_drive}), 32'(2'b01));
    #2 i_rst_n = 1'b0;
    #1 checkOutput("async_reset_outputs", 32'(outVec), 32'(8'b1110_0000));
    doneSeen = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      doneSeen = doneSeen | o_done;
    end
    i_rst_n = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      doneSeen = doneSeen | o_done;
    end
    checkOutput("reset_no_done", 32'(doneSeen), 32'd0);
    checkOutput("post_reset_outputs", 32'(outVec), 32'(8'b1110_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
